// File: rtl/sram_bus_arbiter.sv
// Two-port (fetch/data) arbiter driving one asynchronous SRAM through an IDLE/ACCESS/HOLD/DONE sequence.
// Optional SRAM_ARB_ROUND_ROBIN_EN replaces fixed data priority with last-owner tie breaking.
module sram_bus_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   output logic [31:0]       inst_rdata_o,
   output logic              inst_ready_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [3:0]        data_be_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [31:0]       data_wdata_i,
   output logic [31:0]       data_rdata_o,
   output logic              data_ready_o,
   output logic              stall_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic [3:0]        sram_be_n_o,
   output logic [31:0]       sram_wdata_o,
   output logic              sram_drive_o,
   input  logic [31:0]       sram_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic [3:0]        be_n_q, be_n_d;
   logic              drive_q, drive_d;
   logic [31:0]       inst_rdata_q, inst_rdata_d;
   logic [31:0]       data_rdata_q, data_rdata_d;
   logic              inst_ready_q, inst_ready_d;
   logic              data_ready_q, data_ready_d;

   logic gnt_any, gnt_data, gnt_wr;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // last_q: 1 = data port owned the previous grant, 0 = fetch port
   logic last_q, last_d;
   assign gnt_data = data_req_i & (~inst_req_i | ~last_q);
`else
   assign gnt_data = data_req_i;
`endif

   assign gnt_any = data_req_i | inst_req_i;
   assign gnt_wr  = gnt_data & data_we_i;
   assign stall_o = (inst_req_i & ~inst_ready_q) | (data_req_i & ~data_ready_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      we_d         = we_q;
      be_d         = be_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ce_n_d       = 1'b1;
      oe_n_d       = 1'b1;
      we_n_d       = 1'b1;
      be_n_d       = 4'hF;
      drive_d      = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_ready_d = 1'b0;
      data_ready_d = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_d       = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d = ACCESS;
               cnt_d   = CNT_INIT;
               owner_d = gnt_data;
               we_d    = gnt_wr;
               be_d    = data_be_i;
               addr_d  = gnt_data ? data_addr_i : inst_addr_i;
               wdata_d = gnt_data ? data_wdata_i : wdata_q;
               ce_n_d  = 1'b0;
               if (gnt_wr) begin
                  we_n_d  = 1'b0;
                  be_n_d  = ~data_be_i;
                  drive_d = 1'b1;
               end else begin
                  oe_n_d = 1'b0;
                  be_n_d = 4'h0;
               end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
               last_d = gnt_data;
`endif
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (we_q) begin
                  // write hold: strobe released while address/data/bus stay driven
                  state_d = HOLD;
                  ce_n_d  = 1'b0;
                  be_n_d  = ~be_q;
                  drive_d = 1'b1;
               end else begin
                  state_d      = DONE;
                  inst_ready_d = ~owner_q;
                  data_ready_d = owner_q;
                  if (owner_q) data_rdata_d = sram_rdata_i;
                  else         inst_rdata_d = sram_rdata_i;
               end
            end else begin
               cnt_d  = cnt_q - 4'd1;
               ce_n_d = 1'b0;
               if (we_q) begin
                  we_n_d  = 1'b0;
                  be_n_d  = ~be_q;
                  drive_d = 1'b1;
               end else begin
                  oe_n_d = 1'b0;
                  be_n_d = 4'h0;
               end
            end
         end
         HOLD: begin
            state_d      = DONE;
            inst_ready_d = ~owner_q;
            data_ready_d = owner_q;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         be_q         <= 4'h0;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         be_n_q       <= 4'hF;
         drive_q      <= 1'b0;
         inst_rdata_q <= 32'h0;
         data_rdata_q <= 32'h0;
         inst_ready_q <= 1'b0;
         data_ready_q <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         be_q         <= be_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         be_n_q       <= be_n_d;
         drive_q      <= drive_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_ready_q <= inst_ready_d;
         data_ready_q <= data_ready_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_q       <= last_d;
`endif
      end
   end

   assign sram_addr_o  = addr_q;
   assign sram_wdata_o = wdata_q;
   assign sram_ce_n_o  = ce_n_q;
   assign sram_oe_n_o  = oe_n_q;
   assign sram_we_n_o  = we_n_q;
   assign sram_be_n_o  = be_n_q;
   assign sram_drive_o = drive_q;
   assign inst_rdata_o = inst_rdata_q;
   assign data_rdata_o = data_rdata_q;
   assign inst_ready_o = inst_ready_q;
   assign data_ready_o = data_ready_q;

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one external asynchronous SRAM bus between the instruction-fetch port and the data port, downstream of the address-translation stage.
- Accepts one request per port, with 20-bit word addresses that are already physical, and grants one access at a time.
- Sequences SRAM chip enable, output enable, write enable and byte enables through a multi-cycle state machine.
- Returns read data with a one-cycle ready pulse and raises a pipeline stall while any request is outstanding.

Parameters:
- WAIT_CYCLES, 1: number of strobe cycles in ACCESS, legal range 1..15.
- ADDR_W, 20: SRAM word-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inst_req_i  in  1  fetch request, held until inst_ready_o
- inst_addr_i  in  ADDR_W  fetch word address
- inst_rdata_o  out  32  fetched word
- inst_ready_o  out  1  one-cycle completion pulse
- data_req_i  in  1  data request, held until data_ready_o
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  active-high byte enables
- data_addr_i  in  ADDR_W  data word address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load data
- data_ready_o  out  1  one-cycle completion pulse
- stall_o  out  1  (inst_req_i & ~inst_ready_o) | (data_req_i & ~data_ready_o), combinational
- sram_addr_o  out  ADDR_W  SRAM address
- sram_ce_n_o  out  1  chip enable, active-low
- sram_oe_n_o  out  1  output enable, active-low
- sram_we_n_o  out  1  write enable, active-low
- sram_be_n_o  out  4  byte enables, active-low
- sram_wdata_o  out  32  write data
- sram_drive_o  out  1  1 = drive data bus (tristate control)
- sram_rdata_i  in  32  SRAM read data

Behaviour:
- Clocking and reset: single clock domain. All state and outputs are registered except stall_o.
- Reset values: state = IDLE; ce_n, oe_n and we_n = 1; be_n = 4'hF; drive = 0; sram_addr and sram_wdata = 0; both rdata = 0; both ready = 0; wait counter = 0.
- States: IDLE, ACCESS, HOLD, DONE.
- IDLE, arbitration:
  - data_req_i has priority over inst_req_i.
  - On grant, latch address, we, be, wdata and the owner bit; load counter = WAIT_CYCLES-1; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - ce_n = 0 and sram_addr = latched address.
  - Read: oe_n = 0, be_n = 4'h0.
  - Write: we_n = 0, be_n = ~be, drive = 1, sram_wdata = latched data.
  - Counter decrements each cycle. When the counter is 0:
    - read: capture sram_rdata_i into the owner's rdata register and go to DONE;
    - write: go to HOLD.
- HOLD (write only): we_n = 1; ce_n, address, data and drive stay asserted for one cycle; then go to DONE.
- DONE: all strobes deasserted, drive = 0; owner's ready = 1 for exactly this cycle; next state IDLE unconditionally.
- Request handshake: requesters sample ready at the clock edge and must deassert or change their request at that same edge. IDLE follows DONE, so there are no back-to-back grants.
- Latency, request first seen in IDLE to ready pulse:
  - read: WAIT_CYCLES+1 cycles;
  - write: WAIT_CYCLES+2 cycles.
  - With the default WAIT_CYCLES = 1: read = 2, write = 3.
- The rdata registers hold their value until the next completed read for the same port.
- Simultaneous requests: data is served first; inst is served immediately after, in the next IDLE.
- Request drop: a request withdrawn mid-access does not abort the access; the access completes, and the ready pulse is still issued.
- data_be_i = 0 on a write: the cycle sequence runs as normal with be_n = 4'hF, so no bytes are written; ready is still issued.
- Reset asserted in any state: next edge forces IDLE and strobes high; no ready pulse; an in-flight write is abandoned.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined: a last-owner bit, reset to inst, decides ties when both ports request in IDLE. The port not served last wins. The bit updates on every grant.
- Undefined: fixed data-over-inst priority as above, and the last-owner bit is absent.

Test Plan:
- Reset, then inst read of addr 0x00010 with SRAM returning 0x12345678 → ce_n/oe_n low 1 cycle; inst_ready_o high 2 cycles after req; inst_rdata_o = 0x12345678; stall_o = 1 for 2 cycles.
- Data write: addr 0x00020, data 0xA5A5A5A5, be 4'b0011 → we_n low 1 cycle, then HOLD with we_n high; be_n = 4'b1100; drive high 2 cycles; data_ready_o 3 cycles after req.
- inst_req_i and data_req_i asserted together, both reads → data served first (data_ready at cycle 2), inst next (inst_ready at cycle 5). With SRAM_ARB_ROUND_ROBIN_EN after a prior data access, inst is served first.
- WAIT_CYCLES = 3, read → oe_n low exactly 3 cycles; ready at cycle 4; rdata sampled in the last ACCESS cycle.
- rst pulsed during ACCESS of a write → next cycle we_n = ce_n = 1, drive = 0, state IDLE; no data_ready_o pulse.
- inst_req_i held for 3 consecutive accesses → ready pulses 3 cycles apart, one per DONE; no grant in DONE.
